// File: rtl/uart_transmitter.sv
// UART transmitter: baud-tick generator, frame/config latch, parity calculator
// and start/data/parity/stop sequencer on a single clock domain.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       stop_bits,
  input  logic       data_length,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       parity_out,
  output logic       tx_active,
  output logic       tx_done
);

  localparam logic [14:0] LAST_2400  = 15'(CLK_FREQ / 2400  - 1);
  localparam logic [14:0] LAST_4800  = 15'(CLK_FREQ / 4800  - 1);
  localparam logic [14:0] LAST_9600  = 15'(CLK_FREQ / 9600  - 1);
  localparam logic [14:0] LAST_19200 = 15'(CLK_FREQ / 19200 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [14:0] r_baud_cnt;
  logic [1:0]  r_baud_sel;
  logic [14:0] w_baud_last;
  logic        w_tick;

  logic [2:0]  r_state;
  logic [7:0]  r_data;
  logic [7:0]  r_shift;
  logic        r_len8;
  logic [1:0]  r_par_type;
  logic        r_stop2;
  logic [2:0]  r_bit_cnt;
  logic        r_stop_cnt;
  logic        r_tx;
  logic        r_active;
  logic        r_done;

  logic        w_data_xor;
  logic        w_parity;
  logic        w_par_en;
  logic [2:0]  w_last_bit;

  always_comb begin
    w_baud_last = LAST_2400;
    case (baud_rate)
      2'b00:   w_baud_last = LAST_2400;
      2'b01:   w_baud_last = LAST_4800;
      2'b10:   w_baud_last = LAST_9600;
      default: w_baud_last = LAST_19200;
    endcase
  end

  assign w_tick = (r_baud_cnt == w_baud_last);

  // r_baud_sel remembers the previous selection so a rate change restarts the bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_baud_sel <= '0;
    end else begin
      r_baud_sel <= baud_rate;
      if ((baud_rate != r_baud_sel) || w_tick)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + 15'd1;
    end
  end

  always_comb begin
    w_data_xor = r_len8 ? (^r_data) : (^r_data[6:0]);
    w_parity   = 1'b0;
    case (r_par_type)
      2'b01:   w_parity = ~w_data_xor;
      2'b10:   w_parity = w_data_xor;
      default: w_parity = 1'b0;
    endcase
  end

  assign w_par_en   = (r_par_type == 2'b01) || (r_par_type == 2'b10);
  assign w_last_bit = r_len8 ? 3'd7 : 3'd6;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_shift    <= '0;
      r_len8     <= 1'b0;
      r_par_type <= '0;
      r_stop2    <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (send) begin
              r_data     <= data_in;
              r_shift    <= data_in;
              r_len8     <= data_length;
              r_par_type <= parity_type;
              r_stop2    <= stop_bits;
              r_tx       <= 1'b0;
              r_active   <= 1'b1;
              r_state    <= S_START;
            end
          end
          S_START: begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
          S_DATA: begin
            if (r_bit_cnt == w_last_bit) begin
              if (w_par_en) begin
                r_tx    <= w_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_PARITY: begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
          S_STOP: begin
            if (r_stop_cnt == r_stop2) begin
              r_tx     <= 1'b1;
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
          default: begin
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx         = r_tx;
  assign parity_out = w_parity;
  assign tx_active  = r_active;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: expected frames are queued when a send
// is driven and checked bit-by-bit by a line monitor at mid-bit.
module tb_uart_transmitter;

  localparam int unsigned CLKF = 96_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b1;
  logic [1:0] baud_rate = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       parity_out;
  logic       tx_active;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_transmitter #(.CLK_FREQ(CLKF)) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .stop_bits   (stop_bits),
    .data_length (data_length),
    .baud_rate   (baud_rate),
    .parity_type (parity_type),
    .data_in     (data_in),
    .tx          (tx),
    .parity_out  (parity_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done)
  );

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          div;
    logic        par;
  } frame_t;

  frame_t sb[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [1:0] br);
    case (br)
      2'b00:   return int'(CLKF / 2400);
      2'b01:   return int'(CLKF / 4800);
      2'b10:   return int'(CLKF / 9600);
      default: return int'(CLKF / 19200);
    endcase
  endfunction

  function automatic frame_t mk(input logic [7:0] d, input logic l8, input logic [1:0] pt,
                                input logic s2, input int div);
    frame_t f;
    int     k;
    logic   x;
    f.bits = '1;
    f.bits[0] = 1'b0;
    k = 1;
    x = 1'b0;
    for (int i = 0; i < (l8 ? 8 : 7); i++) begin
      f.bits[k] = d[i];
      x = x ^ d[i];
      k++;
    end
    f.par = (pt == 2'b10) ? x : (pt == 2'b01) ? ~x : 1'b0;
    if (pt == 2'b01 || pt == 2'b10) begin
      f.bits[k] = f.par;
      k++;
    end
    k += s2 ? 2 : 1;
    f.n   = k;
    f.div = div;
    return f;
  endfunction

  // Line monitor: cnt counts clocks from the first negedge that shows the start bit
  frame_t cur;
  bit     busy = 1'b0;
  int     cnt = 0;
  logic   prev_tx = 1'b1;

  always @(negedge clk) begin
    int k;
    if (rst) begin
      busy    = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!busy && prev_tx && !tx) begin
        if (sb.size() == 0) begin
          chk("spurious_start", 32'(1), 32'(0));
        end else begin
          cur  = sb.pop_front();
          busy = 1'b1;
          cnt  = 0;
        end
      end else if (busy) begin
        cnt++;
      end
      if (tx_done && !(busy && cnt == cur.n * cur.div))
        chk("done_spurious", 32'(tx_done), 32'(0));
      if (busy) begin
        k = cnt / cur.div;
        if ((cnt % cur.div) == (cur.div / 2) && k < cur.n) begin
          chk($sformatf("bit%0d", k), 32'(tx), 32'(cur.bits[k]));
          chk("active_in_frame", 32'(tx_active), 32'(1));
          if (k == 1) chk("parity_out", 32'(parity_out), 32'(cur.par));
        end
        if (cnt == cur.n * cur.div - 1) chk("done_early", 32'(tx_done), 32'(0));
        if (cnt == cur.n * cur.div) begin
          chk("done_pulse", 32'(tx_done), 32'(1));
          chk("active_end", 32'(tx_active), 32'(0));
          chk("tx_idle_end", 32'(tx), 32'(1));
        end
        if (cnt == cur.n * cur.div + 1) begin
          chk("done_width", 32'(tx_done), 32'(0));
          busy = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wait_active(input int budget);
    for (int i = 0; i < budget && !tx_active; i++) @(negedge clk);
    chk("start_seen", 32'(tx_active), 32'(1));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || busy); i++) @(negedge clk);
    chk("drain", 32'((sb.size() != 0) || busy), 32'(0));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic l8, input logic [1:0] pt,
                            input logic s2, input logic [1:0] br);
    @(negedge clk);
    data_in     = d;
    data_length = l8;
    parity_type = pt;
    stop_bits   = s2;
    baud_rate   = br;
    sb.push_back(mk(d, l8, pt, s2, div_of(br)));
    send = 1'b1;
    wait_active(4 * div_of(br));
    send = 1'b0;
    wait_drain(16 * div_of(br));
  endtask

  initial begin
    int gap;
    repeat (4) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_active", 32'(tx_active), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    chk("rst_parity", 32'(parity_out), 32'(0));
    rst = 1'b0;
    for (int b = 0; b < 3; b++) begin
      repeat (div_of(2'b10)) @(negedge clk);
      chk("idle_tx", 32'(tx), 32'(1));
      chk("idle_active", 32'(tx_active), 32'(0));
      chk("idle_done", 32'(tx_done), 32'(0));
    end

    send_frame(8'h24, 1'b1, 2'b10, 1'b1, 2'b10);
    send_frame(8'h81, 1'b0, 2'b01, 1'b0, 2'b10);
    send_frame(8'hFF, 1'b1, 2'b00, 1'b0, 2'b10);
    chk("par_none_00", 32'(parity_out), 32'(0));
    send_frame(8'hFF, 1'b1, 2'b11, 1'b1, 2'b10);
    chk("par_none_11", 32'(parity_out), 32'(0));

    for (int r = 0; r < 3; r++)
      send_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'b00);

    // Back-to-back frames with send held and data changed mid-frame
    @(negedge clk);
    baud_rate = 2'b01; data_length = 1'b1; parity_type = 2'b10; stop_bits = 1'b0;
    data_in = 8'h5A;
    sb.push_back(mk(8'h5A, 1'b1, 2'b10, 1'b0, div_of(2'b01)));
    send = 1'b1;
    wait_active(4 * div_of(2'b01));
    repeat (3 * div_of(2'b01)) @(negedge clk);
    data_in = 8'hC3;
    sb.push_back(mk(8'hC3, 1'b1, 2'b10, 1'b0, div_of(2'b01)));
    for (int i = 0; i < 16 * div_of(2'b01) && !tx_done; i++) @(negedge clk);
    chk("b2b_done1", 32'(tx_done), 32'(1));
    gap = 0;
    for (int i = 0; i < 4 * div_of(2'b01) && !tx_active; i++) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'(div_of(2'b01)));
    send = 1'b0;
    wait_drain(16 * div_of(2'b01));

    // Abort during DATA at 19200
    @(negedge clk);
    baud_rate = 2'b11; data_in = 8'h3C; parity_type = 2'b10; stop_bits = 1'b1;
    sb.push_back(mk(8'h3C, 1'b1, 2'b10, 1'b1, div_of(2'b11)));
    send = 1'b1;
    wait_active(4 * div_of(2'b11));
    send = 1'b0;
    repeat (2 * div_of(2'b11) + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'(1));
    chk("abort_active", 32'(tx_active), 32'(0));
    chk("abort_done", 32'(tx_done), 32'(0));
    sb.delete();
    rst = 1'b0;
    for (int b = 0; b < 3 * div_of(2'b11); b++) begin
      @(negedge clk);
      if (tx_done) chk("abort_no_done", 32'(tx_done), 32'(0));
    end
    chk("abort_idle_tx", 32'(tx), 32'(1));
    chk("abort_idle_active", 32'(tx_active), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Configurable UART transmitter on a single clock domain.
- Integrates a baud-tick generator, a transmit data/config latch, a parity calculator and a parallel-in/serial-out frame sequencer.
- Serialises one 7- or 8-bit word per frame on `tx`: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
- Sits between a host interface (`send`/`data_in`) and the serial line.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; baud divisors are CLK_FREQ/baud.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- send, input, 1, level request to transmit `data_in`.
- stop_bits, input, 1, 0 = one stop bit, 1 = two stop bits.
- data_length, input, 1, 0 = 7 data bits (`data_in[6:0]`), 1 = 8 data bits.
- baud_rate, input, 2, 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- parity_type, input, 2, 00 = none, 01 = odd, 10 = even, 11 = none.
- data_in, input, 8, word to transmit.
- tx, output, 1, serial line; idle high.
- parity_out, output, 1, parity bit of the latched word.
- tx_active, output, 1, high while a frame is on the line.
- tx_done, output, 1, one-clk pulse at frame completion.

Behaviour:
- Clock: one clock (`clk`). Reset is synchronous and active-high (`rst`).
- Reset values: tx = 1, tx_active = 0, tx_done = 0, parity_out = 0. Baud counter, bit counter and data latch are cleared; state = IDLE.
- Baud generator:
  - Divisor = CLK_FREQ/baud, truncated. At 50 MHz: 20833, 10416, 5208, 2604.
  - Free-running counter 0..divisor-1; `tick` is high for one clk when the count equals divisor-1, then the count wraps to 0.
  - Any change of `baud_rate` clears the counter on the next clk.
  - Counter width: 15 bits.
- Frame start:
  - In IDLE, on a tick with send = 1: latch `data_in`, `data_length`, `parity_type` and `stop_bits`.
  - Drive tx = 0 (START) and set tx_active = 1.
  - `send` is ignored outside IDLE. Input changes during a frame do not affect that frame.
- States and transitions (each advance occurs on a tick):
  - IDLE → START.
  - START → DATA.
  - DATA shifts 7 or 8 bits, LSB first.
  - DATA → PARITY if parity is enabled, else → STOP.
  - PARITY → STOP.
  - STOP lasts 1 or 2 bit times.
  - STOP → IDLE.
- Bit timing: every bit is held for exactly one tick period.
- Parity:
  - Computed combinationally from the latched word over 7 or 8 bits.
  - Even: XOR of the data bits. Odd: inverted XOR. None: 0.
  - `parity_out` always reflects the latched word. The PARITY bit on `tx` equals `parity_out`.
- Completion:
  - On the tick ending the last stop bit: state → IDLE, tx = 1, tx_active = 0, tx_done = 1 for exactly one clk.
- Back-to-back frames:
  - If `send` is still high, the next frame starts on the following tick.
  - This guarantees at least one idle bit time between frames.
- Frame length: 9 to 12 bit times.
- Mid-frame reset: `rst` aborts immediately to reset values. No tx_done pulse is produced.

Test Plan:
- Reset, then rst = 0 with send = 0 for 3 bit times → tx = 1, tx_active = 0, tx_done = 0 throughout.
- baud_rate = 10, data_length = 1, parity_type = 10, stop_bits = 1, data_in = 0x24, send pulsed high for one tick:
  - tx sequence per 5208-clk bit: 0, 0,0,1,0,0,1,0,0, parity 0, 1, 1.
  - tx_active high for 12 bits; single tx_done pulse.
- data_length = 0, parity_type = 01, stop_bits = 0, data_in = 0x81:
  - 7 bits 1,0,0,0,0,0,0 transmitted; odd parity bit = 0; 10-bit frame.
- parity_type = 00 and 11, data_in = 0xFF → no parity bit; parity_out = 0; frame of 10/11 bits per stop_bits.
- send held high, data_in changed mid-frame → current frame unchanged. Next frame carries the new value after exactly one idle bit time. tx_done pulses once per frame.
- baud_rate = 11 → bit period 2604 clks. Assert rst during DATA → tx = 1 and tx_active = 0 on the next clk, with no tx_done pulse.
